// File: rtl/dct_mfcc_pkg.sv
// Shared widths, FSM states and the output saturation helper for the cepstral DCT engine.
package dct_mfcc_pkg;

  localparam int IN_W   = 16;
  localparam int COEF_W = 9;
  localparam int N_IN   = 32;
  localparam int N_OUT  = 16;
  localparam int ADDR_W = 9;
  localparam int ACC_W  = 30;
  localparam int SHIFT  = 8;
  localparam int OUT_W  = 16;

  localparam int NI_W   = $clog2(N_IN);
  localparam int K_W    = $clog2(N_OUT);
  localparam int CYC_W  = NI_W + 1;
  localparam int PROD_W = IN_W + COEF_W;
  // Last CALC cycle: N_IN issue cycles followed by two pipeline drain cycles.
  localparam int CALC_LAST = N_IN + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

  // Truncating arithmetic shift, then clamp into the signed output range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_MAX)      saturate = SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) saturate = SAT_MIN[OUT_W-1:0];
    else                  saturate = s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dct_mfcc_engine_mac.sv
// Two-stage signed multiply/accumulate: registered product, then accumulate (restart on first term).
// res_o is the shifted and saturated accumulator, valid two cycles after the last issued term.
module dct_mac_pipe
  import dct_mfcc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_vld_i,
  input  logic                     first_i,
  input  logic signed [IN_W-1:0]   sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [OUT_W-1:0]  res_o
);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld_q;
  logic                     prod_first_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign sample_ext = {{COEF_W{sample_i[IN_W-1]}}, sample_i};
  assign coef_ext   = {{IN_W{coef_i[COEF_W-1]}}, coef_i};
  assign prod_ext   = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      acc_q        <= '0;
    end else begin
      prod_q       <= sample_ext * coef_ext;
      prod_vld_q   <= issue_vld_i;
      prod_first_q <= first_i;
      if (prod_vld_q) begin
        acc_q <= prod_first_q ? prod_ext : acc_q + prod_ext;
      end
    end
  end

  assign res_o = saturate(acc_q);

endmodule

// File: rtl/dct_mfcc_engine.sv
// Cepstral DCT over a buffered 32-sample log-mel frame, one MAC per cycle against an external cosine ROM.
// First output 35 cycles after the last sample; output held while out_ready is low, no frame overlap.
module dct_mfcc_engine
  import dct_mfcc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COEF_W-1:0] rom_data,
  output logic [OUT_W-1:0]  out_data,
  output logic [K_W-1:0]    out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e             state_q;
  logic [NI_W-1:0]    wr_cnt_q;
  logic [K_W-1:0]     k_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [K_W-1:0]     out_index_q;
  logic               out_last_q;
  logic [IN_W-1:0]    smp_q [N_IN];

  logic               issue_vld;
  logic               first_issue;
  logic signed [OUT_W-1:0] mac_res;

  // Frame store: plain registers, no reset needed since every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready_q) begin
      smp_q[wr_cnt_q] <= in_data;
    end
  end

  assign issue_vld   = (state_q == CALC) && (cyc_q < CYC_W'(N_IN));
  assign first_issue = (cyc_q == '0);

  dct_mac_pipe u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_vld_i (issue_vld),
    .first_i     (first_issue),
    .sample_i    (smp_q[cyc_q[NI_W-1:0]]),
    .coef_i      (rom_data),
    .res_o       (mac_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      k_q         <= '0;
      cyc_q       <= '0;
      rom_addr_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            wr_cnt_q <= wr_cnt_q + NI_W'(1);
            if (wr_cnt_q == NI_W'(N_IN-1)) begin
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              cyc_q      <= '0;
              rom_addr_q <= {k_q, {NI_W{1'b0}}};
            end
          end
        end
        CALC: begin
          cyc_q <= cyc_q + CYC_W'(1);
          // Address runs one ahead of the multiplier; it parks on the last term during drain.
          if (cyc_q < CYC_W'(N_IN-1)) begin
            rom_addr_q <= {k_q, cyc_q[NI_W-1:0] + NI_W'(1)};
          end
          if (cyc_q == CYC_W'(CALC_LAST)) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= mac_res;
            out_index_q <= k_q;
            out_last_q  <= (k_q == K_W'(N_OUT-1));
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            cyc_q       <= '0;
            k_q         <= k_q + K_W'(1);
            rom_addr_q  <= {k_q + K_W'(1), {NI_W{1'b0}}};
            if (out_last_q) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q <= CALC;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_addr  = rom_addr_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dct_mfcc_engine.sv
// Scoreboard bench for dct_mfcc_engine with a cosine ROM table built from the rounding formula.
module tb_dct_mfcc_engine;

  typedef logic signed [15:0] frame_t [32];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  rom_addr;
  logic [8:0]  rom_data;
  logic [15:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic signed [8:0]  rom_tbl [512];
  logic signed [15:0] exp_q [$];
  logic signed [15:0] got_data [16];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_tbl[rom_addr];

  dct_mfcc_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic build_rom();
    real r;
    int  v;
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 32; n++) begin
        r = 255.0 * $cos(real'(k * (2 * n + 1)) * 3.14159265358979 / 64.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        rom_tbl[k * 32 + n] = 9'(v);
      end
    end
  endtask

  function automatic void push_expected(input frame_t x);
    longint acc;
    longint s;
    for (int k = 0; k < 16; k++) begin
      acc = 0;
      for (int n = 0; n < 32; n++) acc += longint'(x[n]) * longint'(rom_tbl[k * 32 + n]);
      s = acc >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      exp_q.push_back(16'(s));
    end
  endfunction

  // Starts and ends on a falling edge; returns one cycle after the 32nd sample is taken.
  task automatic send_frame(input frame_t x, input bit random_stall);
    int idx = 0;
    int guard = 0;
    push_expected(x);
    while (idx < 32 && guard < 3000) begin
      if (random_stall && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = x[idx];
        if (in_ready) idx++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (idx != 32) begin n_fail++; $display("FAIL load_timeout: accepted %0d want 32", idx); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_ready_after_load: got %b want 0", in_ready); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_load: got %b want 1", busy); end
  endtask

  task automatic collect_frame(input int n_exp, input int stall_k, input int stall_len,
                               input bit junk_in, input bit check_gap);
    int got = 0;
    int guard = 0;
    int hold = 0;
    int gap = 0;
    logic [15:0] hd;
    logic [3:0]  hi;
    logic signed [15:0] e;
    while (got < n_exp && guard < 8000) begin
      gap++;
      if (junk_in) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL in_ready_busy: got %b want 0", in_ready); end
      end
      if (out_valid) begin
        if (int'(out_index) == stall_k && hold < stall_len) begin
          out_ready = 1'b0;
          if (hold == 0) begin
            hd = out_data;
            hi = out_index;
          end else begin
            n_checks++;
            if (out_data !== hd || out_index !== hi) begin
              n_fail++;
              $display("FAIL hold_stable: data %0d idx %0d want data %0d idx %0d", $signed(out_data), out_index, $signed(hd), hi);
            end
          end
          hold++;
        end else begin
          out_ready = 1'b1;
          if (check_gap && got > 0) begin
            n_checks++;
            if (gap != 35) begin n_fail++; $display("FAIL output_gap: got %0d want 35", gap); end
          end
          gap = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: idx %0d data %0d want no output", out_index, $signed(out_data));
          end else begin
            e = exp_q.pop_front();
            if ($signed(out_data) !== e) begin
              n_fail++;
              $display("FAIL out_data[%0d]: got %0d want %0d", got, $signed(out_data), e);
            end
          end
          n_checks++;
          if (out_index !== 4'(got)) begin n_fail++; $display("FAIL out_index: got %0d want %0d", out_index, got); end
          n_checks++;
          if (out_last !== (got == 15)) begin n_fail++; $display("FAIL out_last[%0d]: got %b want %b", got, out_last, got == 15); end
          if (got < 16) got_data[got] = out_data;
          got++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got != n_exp) begin n_fail++; $display("FAIL collect_timeout: got %0d outputs want %0d", got, n_exp); end
    if (stall_k >= 0) begin
      n_checks++;
      if (hold != stall_len) begin n_fail++; $display("FAIL stall_seen: got %0d want %0d", hold, stall_len); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready %b out_valid %b busy %b want 1 0 0", in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_data !== 16'd0 || out_index !== 4'd0 || out_last !== 1'b0 || rom_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_data: data %0d idx %0d last %b addr %0d want 0 0 0 0", out_data, out_index, out_last, rom_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    frame_t f;
    for (int n = 0; n < 32; n++) f[n] = 16'sd0;
    send_frame(f, 1'b0);
    collect_frame(16, -1, 0, 1'b0, 1'b0);
    n_checks++;
    if (got_data[0] !== 16'sd0 || got_data[15] !== 16'sd0) begin
      n_fail++;
      $display("FAIL zero_frame: y0 %0d y15 %0d want 0 0", got_data[0], got_data[15]);
    end
  endtask

  task automatic test_dc();
    frame_t f;
    int lat = 1;
    for (int n = 0; n < 32; n++) f[n] = 16'sd1000;
    send_frame(f, 1'b0);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 35) begin n_fail++; $display("FAIL first_latency: got %0d want 35", lat); end
    collect_frame(16, -1, 0, 1'b0, 1'b1);
    n_checks++;
    if (got_data[0] !== 16'sd31875) begin n_fail++; $display("FAIL dc_y0: got %0d want 31875", got_data[0]); end
  endtask

  task automatic test_saturation();
    frame_t f;
    for (int n = 0; n < 32; n++) f[n] = 16'sh7FFF;
    send_frame(f, 1'b0);
    collect_frame(16, -1, 0, 1'b0, 1'b0);
    n_checks++;
    if (got_data[0] !== 16'sh7FFF) begin n_fail++; $display("FAIL sat_pos: got %0d want 32767", got_data[0]); end
    for (int n = 0; n < 32; n++) f[n] = 16'sh8000;
    send_frame(f, 1'b0);
    collect_frame(16, -1, 0, 1'b0, 1'b0);
    n_checks++;
    if (got_data[0] !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg: got %0d want -32768", got_data[0]); end
  endtask

  task automatic test_backpressure();
    frame_t f;
    for (int n = 0; n < 32; n++) f[n] = 16'($urandom_range(0, 8000)) - 16'sd4000;
    send_frame(f, 1'b0);
    collect_frame(16, 3, 10, 1'b0, 1'b0);
  endtask

  task automatic test_stall_flow();
    frame_t f;
    for (int n = 0; n < 32; n++) f[n] = 16'($urandom);
    send_frame(f, 1'b1);
    collect_frame(16, -1, 0, 1'b1, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_last: in_ready %b busy %b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_mid_reset();
    frame_t f;
    for (int n = 0; n < 32; n++) f[n] = 16'($urandom_range(0, 2000));
    send_frame(f, 1'b0);
    collect_frame(7, -1, 0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rom_addr[8:5] !== 4'd7) begin
      n_fail++;
      $display("FAIL calc_k7: busy %b out_valid %b addr %0d want busy 1 valid 0 k 7", busy, out_valid, rom_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 9'd0 ||
        out_data !== 16'd0 || out_index !== 4'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy %b vld %b busy %b addr %0d data %0d idx %0d last %b want 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, rom_addr, out_data, out_index, out_last);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 32; n++) f[n] = 16'($urandom);
    send_frame(f, 1'b0);
    collect_frame(16, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    frame_t f;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 32; n++) f[n] = 16'($urandom);
      send_frame(f, 1'b0);
      collect_frame(16, -1, 0, 1'b0, 1'b1);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    build_rom();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_zero();
    test_dc();
    test_saturation();
    test_backpressure();
    test_stall_flow();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
